// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Single-clock parametrised FIFO with a registered occupancy
//               count, almost-full/almost-empty thresholds, sticky
//               overflow/underflow flags and a selectable read mode
//               (registered read or first-word-fall-through).
// Ports       : clk          - single clock, rising edge
//               rst_n        - asynchronous active-low reset
//               data_in      - write data (DSIZE)
//               w_en         - write request
//               r_en         - read/pop request
//               clr_err      - clears overflow/underflow
//               data_out     - read data (DSIZE)
//               full/empty   - count == DEPTH / count == 0
//               almost_full  - count >= AF_LEVEL
//               almost_empty - count <= AE_LEVEL
//               count        - occupancy 0..DEPTH (ASIZE+1)
//               overflow     - sticky, write attempted while full
//               underflow    - sticky, read attempted while empty
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] data_in,
    input  logic             w_en,
    input  logic             r_en,
    input  logic             clr_err,
    output logic [DSIZE-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int             DEPTH     = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_CNT = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AF_CNT    = (ASIZE+1)'(AF_LEVEL);
    localparam logic [ASIZE:0] AE_CNT    = (ASIZE+1)'(AE_LEVEL);
    localparam logic [ASIZE:0] ONE       = (ASIZE+1)'(1);

    // Reject illegal threshold/size combinations at elaboration time.
    generate
        if (ASIZE < 1 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_params
            $error("sync_fifo_param: require ASIZE>=1 and 0 <= AE_LEVEL < AF_LEVEL <= 2**ASIZE");
        end
    endgenerate

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [ASIZE:0]   wptr_q, wptr_d;
    logic [ASIZE:0]   rptr_q, rptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_ok;
    logic             rd_ok;

    // Flags come from the registered count, so they move on the same edge.
    assign full         = (count_q == DEPTH_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Acceptance looks only at pre-edge flags: a simultaneous read does not
    // free space for a write at full, and a simultaneous write does not
    // supply data for a read at empty.
    assign wr_ok = w_en & ~full;
    assign rd_ok = r_en & ~empty;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_ok) wptr_d = wptr_q + ONE;
        if (rd_ok) rptr_d = rptr_q + ONE;

        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase

        // Setting has priority over clearing on the same edge.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (w_en & full)  overflow_d  = 1'b1;
        if (r_en & empty) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never reset; stale entries are unreachable while empty.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wptr_q[ASIZE-1:0]] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is always presented; meaningless while empty.
            assign data_out = mem_q[rptr_q[ASIZE-1:0]];
        end else begin : g_reg_read
            logic [DSIZE-1:0] dout_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q <= '0;
                end else if (rd_ok) begin
                    dout_q <= mem_q[rptr_q[ASIZE-1:0]];
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule
`default_nettype wire
